// File: rtl/dtcm_arb_pkg.sv
// Shared types and constants for the DTCM arbiter slice.
//   DTCM_ADDR_WIDTH / DTCM_RAM_DW / DTCM_RAM_MW : DTCM command/response widths
//   DTCM_ARB_SRC_LSU / DTCM_ARB_SRC_EXT         : source IDs tracked in the ID FIFO
//   DTCM_ARB_OUTS_DEPTH                         : default outstanding-command depth
package dtcm_arb_pkg;
  localparam int DTCM_ADDR_WIDTH     = 32;
  localparam int DTCM_RAM_DW         = 32;
  localparam int DTCM_RAM_MW         = 4;
  localparam int DTCM_ARB_OUTS_DEPTH = 2;

  localparam logic DTCM_ARB_SRC_LSU = 1'b0;
  localparam logic DTCM_ARB_SRC_EXT = 1'b1;
endpackage

// File: rtl/dtcm_arb_id_fifo.sv
// In-order source-ID FIFO (1 bit wide) recording which requester owns each
// outstanding DTCM command.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push_i, din_i   : enqueue one source ID
//   pop_i           : dequeue head (caller guarantees not empty)
//   full_o, empty_o : occupancy flags
//   head_o          : source ID at the head
module dtcm_arb_id_fifo
  import dtcm_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  // A depth-1 FIFO still needs a 1-bit pointer to keep the code uniform;
  // the wrap compare pins it at 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = ptr_inc(wptr_q);
    if (pop_i)  rptr_d = ptr_inc(rptr_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage: each slot loads only when the write pointer selects it.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (rst)                                mem_q[i] <= DTCM_ARB_SRC_LSU;
      else if (push_i && wptr_q == PW'(i))    mem_q[i] <= din_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/dtcm_arbiter.sv
// Two-port arbiter in front of dtcm_ctrl: LSU (port 0) and external bus/DMA
// (port 1) share one command/response channel. Commands are granted
// combinationally; each accepted command's source ID is queued so responses
// (returned in order by dtcm_ctrl) are routed back to the issuer.
// Configuration macro: DTCM_ARB_RR_EN -- defined: round-robin on ties;
//   undefined: fixed priority, LSU wins ties.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   lsu_cmd_* / lsu_rsp_*     : LSU command / response channels
//   ext_cmd_* / ext_rsp_*     : external port command / response channels
//   dtcm_cmd_*                : muxed command channel to dtcm_ctrl
//   dtcm_rsp_*                : response channel from dtcm_ctrl
module dtcm_arbiter
  import dtcm_arb_pkg::*;
#(
  parameter int OUTS_DEPTH = DTCM_ARB_OUTS_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  // LSU
  input  logic                       lsu_cmd_valid_i,
  output logic                       lsu_cmd_ready_o,
  input  logic                       lsu_cmd_read_i,
  input  logic [DTCM_ADDR_WIDTH-1:0] lsu_cmd_addr_i,
  input  logic [DTCM_RAM_MW-1:0]     lsu_cmd_wmask_i,
  input  logic [DTCM_RAM_DW-1:0]     lsu_cmd_wdata_i,
  output logic                       lsu_rsp_valid_o,
  input  logic                       lsu_rsp_ready_i,
  output logic [DTCM_RAM_DW-1:0]     lsu_rsp_rdata_o,
  // external bus / DMA
  input  logic                       ext_cmd_valid_i,
  output logic                       ext_cmd_ready_o,
  input  logic                       ext_cmd_read_i,
  input  logic [DTCM_ADDR_WIDTH-1:0] ext_cmd_addr_i,
  input  logic [DTCM_RAM_MW-1:0]     ext_cmd_wmask_i,
  input  logic [DTCM_RAM_DW-1:0]     ext_cmd_wdata_i,
  output logic                       ext_rsp_valid_o,
  input  logic                       ext_rsp_ready_i,
  output logic [DTCM_RAM_DW-1:0]     ext_rsp_rdata_o,
  // dtcm_ctrl
  output logic                       dtcm_cmd_valid_o,
  input  logic                       dtcm_cmd_ready_i,
  output logic                       dtcm_cmd_read_o,
  output logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr_o,
  output logic [DTCM_RAM_MW-1:0]     dtcm_cmd_wmask_o,
  output logic [DTCM_RAM_DW-1:0]     dtcm_cmd_wdata_o,
  input  logic                       dtcm_rsp_valid_i,
  output logic                       dtcm_rsp_ready_o,
  input  logic [DTCM_RAM_DW-1:0]     dtcm_rsp_rdata_i
);
  logic gnt, gnt_vld, accept, can_push, cmd_rdy;
  logic lock_q, lock_d, lock_src_q, lock_src_d;
  logic fifo_full, fifo_empty, fifo_head, push, pop;

`ifdef DTCM_ARB_RR_EN
  logic last_q, last_d;
`endif

  // Grant select: a locked grant wins; otherwise resolve ties by policy.
  always_comb begin
    gnt = DTCM_ARB_SRC_LSU;
    if (lock_q)
      gnt = lock_src_q;
    else if (lsu_cmd_valid_i && ext_cmd_valid_i)
`ifdef DTCM_ARB_RR_EN
      gnt = ~last_q;
`else
      gnt = DTCM_ARB_SRC_LSU;
`endif
    else if (ext_cmd_valid_i)
      gnt = DTCM_ARB_SRC_EXT;
  end

  assign gnt_vld = (gnt == DTCM_ARB_SRC_EXT) ? ext_cmd_valid_i : lsu_cmd_valid_i;

  // A full FIFO may still take a command if the head is retiring this cycle.
  assign pop      = ~rst & ~fifo_empty & dtcm_rsp_valid_i & dtcm_rsp_ready_o;
  assign can_push = ~fifo_full | pop;

  assign dtcm_cmd_valid_o = ~rst & gnt_vld & can_push;
  assign cmd_rdy          = ~rst & dtcm_cmd_ready_i & can_push;
  assign lsu_cmd_ready_o  = cmd_rdy & (gnt == DTCM_ARB_SRC_LSU);
  assign ext_cmd_ready_o  = cmd_rdy & (gnt == DTCM_ARB_SRC_EXT);
  assign accept           = dtcm_cmd_valid_o & dtcm_cmd_ready_i;
  assign push             = accept;

  assign dtcm_cmd_read_o  = gnt ? ext_cmd_read_i  : lsu_cmd_read_i;
  assign dtcm_cmd_addr_o  = gnt ? ext_cmd_addr_i  : lsu_cmd_addr_i;
  assign dtcm_cmd_wmask_o = gnt ? ext_cmd_wmask_i : lsu_cmd_wmask_i;
  assign dtcm_cmd_wdata_o = gnt ? ext_cmd_wdata_i : lsu_cmd_wdata_i;

  // Hold the grant while the granted requester waits for its handshake.
  assign lock_d     = gnt_vld & ~accept;
  assign lock_src_d = gnt;

`ifdef DTCM_ARB_RR_EN
  assign last_d = accept ? gnt : last_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_src_q <= DTCM_ARB_SRC_LSU;
`ifdef DTCM_ARB_RR_EN
      last_q     <= DTCM_ARB_SRC_EXT;
`endif
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
`ifdef DTCM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  dtcm_arb_id_fifo #(.DEPTH(OUTS_DEPTH)) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (gnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Responses go to the head owner. With nothing outstanding (or in reset)
  // stray responses are drained by holding ready high.
  assign dtcm_rsp_ready_o = rst | fifo_empty |
                            (fifo_head ? ext_rsp_ready_i : lsu_rsp_ready_i);
  assign lsu_rsp_valid_o  = ~rst & ~fifo_empty & dtcm_rsp_valid_i &
                            (fifo_head == DTCM_ARB_SRC_LSU);
  assign ext_rsp_valid_o  = ~rst & ~fifo_empty & dtcm_rsp_valid_i &
                            (fifo_head == DTCM_ARB_SRC_EXT);
  assign lsu_rsp_rdata_o  = dtcm_rsp_rdata_i;
  assign ext_rsp_rdata_o  = dtcm_rsp_rdata_i;
endmodule

// File: tb/tb_dtcm_arbiter.sv
module tb_dtcm_arbiter;
  import dtcm_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
  logic [DTCM_ADDR_WIDTH-1:0] lsu_cmd_addr;
  logic [DTCM_RAM_MW-1:0]     lsu_cmd_wmask;
  logic [DTCM_RAM_DW-1:0]     lsu_cmd_wdata;
  logic lsu_rsp_valid, lsu_rsp_ready;
  logic [DTCM_RAM_DW-1:0]     lsu_rsp_rdata;
  logic ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
  logic [DTCM_ADDR_WIDTH-1:0] ext_cmd_addr;
  logic [DTCM_RAM_MW-1:0]     ext_cmd_wmask;
  logic [DTCM_RAM_DW-1:0]     ext_cmd_wdata;
  logic ext_rsp_valid, ext_rsp_ready;
  logic [DTCM_RAM_DW-1:0]     ext_rsp_rdata;
  logic dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr;
  logic [DTCM_RAM_MW-1:0]     dtcm_cmd_wmask;
  logic [DTCM_RAM_DW-1:0]     dtcm_cmd_wdata;
  logic dtcm_rsp_valid, dtcm_rsp_ready;
  logic [DTCM_RAM_DW-1:0]     dtcm_rsp_rdata;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dtcm_arbiter dut (
    .clk(clk), .rst(rst),
    .lsu_cmd_valid_i(lsu_cmd_valid), .lsu_cmd_ready_o(lsu_cmd_ready),
    .lsu_cmd_read_i(lsu_cmd_read), .lsu_cmd_addr_i(lsu_cmd_addr),
    .lsu_cmd_wmask_i(lsu_cmd_wmask), .lsu_cmd_wdata_i(lsu_cmd_wdata),
    .lsu_rsp_valid_o(lsu_rsp_valid), .lsu_rsp_ready_i(lsu_rsp_ready),
    .lsu_rsp_rdata_o(lsu_rsp_rdata),
    .ext_cmd_valid_i(ext_cmd_valid), .ext_cmd_ready_o(ext_cmd_ready),
    .ext_cmd_read_i(ext_cmd_read), .ext_cmd_addr_i(ext_cmd_addr),
    .ext_cmd_wmask_i(ext_cmd_wmask), .ext_cmd_wdata_i(ext_cmd_wdata),
    .ext_rsp_valid_o(ext_rsp_valid), .ext_rsp_ready_i(ext_rsp_ready),
    .ext_rsp_rdata_o(ext_rsp_rdata),
    .dtcm_cmd_valid_o(dtcm_cmd_valid), .dtcm_cmd_ready_i(dtcm_cmd_ready),
    .dtcm_cmd_read_o(dtcm_cmd_read), .dtcm_cmd_addr_o(dtcm_cmd_addr),
    .dtcm_cmd_wmask_o(dtcm_cmd_wmask), .dtcm_cmd_wdata_o(dtcm_cmd_wdata),
    .dtcm_rsp_valid_i(dtcm_rsp_valid), .dtcm_rsp_ready_o(dtcm_rsp_ready),
    .dtcm_rsp_rdata_i(dtcm_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past a clock edge; inputs are then changed and outputs sampled
  // well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 32'h10;
    lsu_cmd_wmask = '0; lsu_cmd_wdata = '0; lsu_rsp_ready = 1'b1;
    ext_cmd_valid = 1'b0; ext_cmd_read = 1'b1; ext_cmd_addr = 32'h20;
    ext_cmd_wmask = '0; ext_cmd_wdata = '0; ext_rsp_ready = 1'b1;
    dtcm_cmd_ready = 1'b1; dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h0;

    // Reset state: nothing visible even with requests/responses presented.
    tick();
    chk("rst_lsu_cmd_ready", 32'(lsu_cmd_ready), 0);
    chk("rst_dtcm_cmd_valid", 32'(dtcm_cmd_valid), 0);
    chk("rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 0);
    chk("rst_ext_rsp_valid", 32'(ext_rsp_valid), 0);
    lsu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b0; rst = 1'b0;
    tick();

    // 1: single LSU read, response next cycle.
    lsu_cmd_valid = 1'b1; #1;
    chk("t1_cmd_valid", 32'(dtcm_cmd_valid), 1);
    chk("t1_cmd_addr", dtcm_cmd_addr, 32'h10);
    chk("t1_lsu_ready", 32'(lsu_cmd_ready), 1);
    tick();
    lsu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'hDEADBEEF; #1;
    chk("t1_lsu_rsp_valid", 32'(lsu_rsp_valid), 1);
    chk("t1_lsu_rdata", lsu_rsp_rdata, 32'hDEADBEEF);
    chk("t1_ext_rsp_valid", 32'(ext_rsp_valid), 0);
    tick();
    dtcm_rsp_valid = 1'b0;

    // 2: both requesting for 8 cycles, one response retired per cycle.
    lsu_cmd_valid = 1'b1; ext_cmd_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dtcm_rsp_valid = (k != 0); #1;
`ifdef DTCM_ARB_RR_EN
      // Previous accept was LSU, so alternation starts with EXT.
      chk($sformatf("t2_lsu_gnt_%0d", k), 32'(lsu_cmd_ready), 32'(k % 2));
      chk($sformatf("t2_ext_gnt_%0d", k), 32'(ext_cmd_ready), 32'(1 - k % 2));
`else
      chk($sformatf("t2_lsu_gnt_%0d", k), 32'(lsu_cmd_ready), 1);
      chk($sformatf("t2_ext_gnt_%0d", k), 32'(ext_cmd_ready), 0);
`endif
      tick();
    end
    // LSU drops: EXT now granted; last outstanding (LSU) retires.
    lsu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b1; #1;
    chk("t2_ext_after_drop", 32'(ext_cmd_ready), 1);
    chk("t2_last_rsp_lsu", 32'(lsu_rsp_valid), 1);
    tick();
    ext_cmd_valid = 1'b0; #1;
    chk("t2_ext_rsp_valid", 32'(ext_rsp_valid), 1);
    chk("t2_lsu_rsp_idle", 32'(lsu_rsp_valid), 0);
    tick();
    dtcm_rsp_valid = 1'b0;

    // 3: EXT stalled by dtcm_cmd_ready=0 keeps the grant when LSU arrives.
    dtcm_cmd_ready = 1'b0; ext_cmd_valid = 1'b1; #1;
    chk("t3_cmd_valid", 32'(dtcm_cmd_valid), 1);
    chk("t3_addr_ext0", dtcm_cmd_addr, 32'h20);
    tick();
    lsu_cmd_valid = 1'b1; #1;
    chk("t3_addr_ext1", dtcm_cmd_addr, 32'h20);
    tick();
    chk("t3_addr_ext2", dtcm_cmd_addr, 32'h20);
    tick();
    dtcm_cmd_ready = 1'b1; #1;
    chk("t3_ext_ready", 32'(ext_cmd_ready), 1);
    chk("t3_lsu_blocked", 32'(lsu_cmd_ready), 0);
    tick();
    ext_cmd_valid = 1'b0; #1;
    chk("t3_lsu_next", 32'(lsu_cmd_ready), 1);
    chk("t3_addr_lsu", dtcm_cmd_addr, 32'h10);
    tick();
    lsu_cmd_valid = 1'b0; dtcm_rsp_valid = 1'b1; #1;
    chk("t3_rsp0_ext", 32'(ext_rsp_valid), 1);
    tick();
    chk("t3_rsp1_lsu", 32'(lsu_rsp_valid), 1);
    tick();
    dtcm_rsp_valid = 1'b0;

    // 4: fill to depth 2, then full push+pop in the same cycle.
    lsu_cmd_addr = 32'h30; lsu_rsp_ready = 1'b0; lsu_cmd_valid = 1'b1; #1;
    chk("t4_acc0", 32'(lsu_cmd_ready), 1);
    tick();
    chk("t4_acc1", 32'(lsu_cmd_ready), 1);
    tick();
    dtcm_rsp_valid = 1'b1; #1;
    chk("t4_full_ready", 32'(lsu_cmd_ready), 0);
    chk("t4_full_valid", 32'(dtcm_cmd_valid), 0);
    chk("t4_rsp_bp", 32'(dtcm_rsp_ready), 0);
    tick();
    lsu_rsp_ready = 1'b1; #1;
    chk("t4_pushpop_ready", 32'(lsu_cmd_ready), 1);
    chk("t4_pushpop_rsp", 32'(dtcm_rsp_ready), 1);
    tick();
    lsu_cmd_valid = 1'b0; #1;
    chk("t4_drain0", 32'(lsu_rsp_valid), 1);
    tick();
    chk("t4_drain1", 32'(lsu_rsp_valid), 1);
    tick();
    dtcm_rsp_valid = 1'b0;

    // 5: interleaved writes L,E,L; command fields follow the issuer.
    lsu_cmd_read = 1'b0; lsu_cmd_wmask = 4'b0011; lsu_cmd_wdata = 32'h1234;
    ext_cmd_read = 1'b0; ext_cmd_wmask = 4'b1100; ext_cmd_wdata = 32'hABCD;
    lsu_cmd_valid = 1'b1; #1;
    chk("t5_l0_mask", 32'(dtcm_cmd_wmask), 32'h3);
    chk("t5_l0_data", dtcm_cmd_wdata, 32'h1234);
    chk("t5_l0_read", 32'(dtcm_cmd_read), 0);
    tick();
    lsu_cmd_valid = 1'b0; ext_cmd_valid = 1'b1; #1;
    chk("t5_e_mask", 32'(dtcm_cmd_wmask), 32'hC);
    chk("t5_e_data", dtcm_cmd_wdata, 32'hABCD);
    tick();
    ext_cmd_valid = 1'b0; lsu_cmd_valid = 1'b1; dtcm_rsp_valid = 1'b1; #1;
    chk("t5_l1_mask", 32'(dtcm_cmd_wmask), 32'h3);
    chk("t5_rsp0_lsu", 32'(lsu_rsp_valid), 1);
    chk("t5_rsp0_ext", 32'(ext_rsp_valid), 0);
    tick();
    lsu_cmd_valid = 1'b0; #1;
    chk("t5_rsp1_ext", 32'(ext_rsp_valid), 1);
    chk("t5_rsp1_lsu", 32'(lsu_rsp_valid), 0);
    tick();
    chk("t5_rsp2_lsu", 32'(lsu_rsp_valid), 1);
    chk("t5_rsp2_ext", 32'(ext_rsp_valid), 0);
    tick();
    dtcm_rsp_valid = 1'b0;

    // 6: reset with two outstanding; late response is drained, not routed.
    lsu_cmd_read = 1'b1; lsu_cmd_valid = 1'b1;
    tick();
    tick();
    lsu_cmd_valid = 1'b0; lsu_rsp_ready = 1'b0; dtcm_rsp_valid = 1'b1; rst = 1'b1; #1;
    chk("t6_rst_lsu_rsp", 32'(lsu_rsp_valid), 0);
    chk("t6_rst_rsp_ready", 32'(dtcm_rsp_ready), 1);
    tick();
    rst = 1'b0; #1;
    chk("t6_stray_lsu", 32'(lsu_rsp_valid), 0);
    chk("t6_stray_ext", 32'(ext_rsp_valid), 0);
    chk("t6_stray_drain", 32'(dtcm_rsp_ready), 1);
    tick();
    dtcm_rsp_valid = 1'b0; lsu_cmd_valid = 1'b1; #1;
    chk("t6_post_accept", 32'(lsu_cmd_ready), 1);
    tick();
    lsu_cmd_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
